// File: rtl/icache_direct_mapped.sv
// ---------------------------------------------------------------------------
// icache_direct_mapped
//   Direct-mapped, read-only instruction cache sitting between the core's
//   fetch port and a slow instruction memory that returns a 4-word line.
//   Hits are served combinationally; a miss stalls the core, fetches the
//   whole line, fills it and returns to IDLE where the current address is
//   re-evaluated.
//
//   Optional build macro: ICACHE_STATS_EN
//     defined   -> saturating 16-bit hit/miss counters are built
//     undefined -> hit_cnt/miss_cnt are tied to zero (ports still present)
// ---------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic [31:0]  proc_addr,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // Cache storage: only valid bits need a reset value
    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [127:0]          r_data [NUM_BLOCKS];

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_mem_read;
    logic [27:0]           r_mem_addr;

    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic [INDEX_W-1:0]    w_fill_index;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_hit;
    logic [127:0]          w_line;
    logic [31:0]           w_word_data;
    logic                  w_stall;
    logic                  w_start_fetch;
    logic                  w_fill;
    logic                  w_unused;

    // Address decomposition of the incoming fetch request
    assign w_index = proc_addr[4+INDEX_W-1:4];
    assign w_tag   = proc_addr[31:4+INDEX_W];
    assign w_word  = proc_addr[3:2];

    // The fill always targets the latched line address, never the live one
    assign w_fill_index = r_mem_addr[INDEX_W-1:0];
    assign w_fill_tag   = r_mem_addr[27:INDEX_W];

    // Byte offset within a word is irrelevant for instruction fetch
    assign w_unused = ^proc_addr[1:0];

    assign w_hit  = proc_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_line = r_data[w_index];

    // Select the requested word out of the indexed line
    always_comb begin
        w_word_data = 32'h0;
        case (w_word)
            2'd0:    w_word_data = w_line[31:0];
            2'd1:    w_word_data = w_line[63:32];
            2'd2:    w_word_data = w_line[95:64];
            2'd3:    w_word_data = w_line[127:96];
            default: w_word_data = 32'h0;
        endcase
    end

    // Drive the instruction word only on a hit, zero otherwise
    always_comb begin
        proc_rdata = 32'h0;
        if (w_hit) begin
            proc_rdata = w_word_data;
        end else begin
            proc_rdata = 32'h0;
        end
    end

    // Next-state and control decode for the miss-handling FSM
    always_comb begin
        w_next_state  = r_state;
        w_stall       = 1'b0;
        w_start_fetch = 1'b0;
        w_fill        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (proc_read && !w_hit) begin
                    w_stall       = 1'b1;
                    w_start_fetch = 1'b1;
                    w_next_state  = ST_FETCH;
                end else begin
                    w_next_state  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_stall = 1'b1;
                if (mem_ready) begin
                    w_fill       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign proc_stall = w_stall;
    assign mem_read   = r_mem_read;
    assign mem_addr   = r_mem_addr;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Memory request: raised with the latched line address on a miss, held until the fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_read <= 1'b0;
            r_mem_addr <= 28'h0;
        end else if (w_start_fetch) begin
            r_mem_read <= 1'b1;
            r_mem_addr <= proc_addr[31:4];
        end else if (w_fill) begin
            r_mem_read <= 1'b0;
        end
    end

    // Valid bits: cleared on reset, set when a line is filled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays: written only on a fill, no reset needed
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;
    logic        w_hit_evt;

    assign w_hit_evt = (r_state == ST_IDLE) & w_hit;

    // Saturating hit counter, counts IDLE cycles that hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= 16'h0;
        end else if (w_hit_evt && (r_hit_cnt != 16'hFFFF)) begin
            r_hit_cnt <= r_hit_cnt + 16'h1;
        end
    end

    // Saturating miss counter, counts IDLE->FETCH transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_cnt <= 16'h0;
        end else if (w_start_fetch && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'h1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
    assign hit_cnt  = 16'h0;
    assign miss_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// ---------------------------------------------------------------------------
// tb_icache_direct_mapped
//   Directed, self-checking bench for icache_direct_mapped. Inputs change
//   1 time unit after a rising edge; combinational outputs are sampled 1 unit
//   later, registered outputs likewise, well before the next edge.
// ---------------------------------------------------------------------------
module tb_icache_direct_mapped;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic [31:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    int errors = 0;
    int checks = 0;

    icache_direct_mapped #(.NUM_BLOCKS(8), .INDEX_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1);
    end

    // Advance to 1 unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        proc_read = 1'b0;
        proc_addr = 32'h0;
        mem_rdata = 128'h0;
        mem_ready = 1'b0;
        step();
        step();
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b exp 0", mem_read); end
        checks++;
        if (mem_addr !== 28'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h exp 0", mem_addr); end
        checks++;
        if (proc_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b exp 0", proc_stall); end
        checks++;
        if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", hit_cnt, miss_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        int stall_cycles;
        stall_cycles = 0;
        proc_read = 1'b1;
        proc_addr = 32'h0;
        #1;
        checks++;
        if (proc_stall !== 1'b1) begin errors++; $display("FAIL cold_stall_now: got %0b exp 1", proc_stall); end
        checks++;
        if (proc_rdata !== 32'h0) begin errors++; $display("FAIL cold_rdata_miss: got %0h exp 0", proc_rdata); end
        if (proc_stall === 1'b1) stall_cycles++;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) begin
                mem_ready = 1'b1;
                mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
            end
            #1;
            if (proc_stall === 1'b1) stall_cycles++;
            if (k == 1) begin
                checks++;
                if (mem_read !== 1'b1 || mem_addr !== 28'h0) begin
                    errors++; $display("FAIL cold_req: got read=%0b addr=%0h exp read=1 addr=0", mem_read, mem_addr);
                end
            end
        end
        step();
        mem_ready = 1'b0;
        mem_rdata = 128'h0;
        #1;
        checks++;
        if (stall_cycles != 5) begin errors++; $display("FAIL cold_stall_len: got %0d exp 5", stall_cycles); end
        checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h11) begin
            errors++; $display("FAIL cold_post_hit: got stall=%0b data=%0h exp stall=0 data=11", proc_stall, proc_rdata);
        end
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("FAIL cold_read_drop: got %0b exp 0", mem_read); end
    endtask

    task automatic test_seq_hits();
        logic [31:0] addrs [3];
        logic [31:0] exp_data [3];
        int exp_hits;
        int exp_miss;
        addrs    = '{32'h4, 32'h8, 32'hC};
        exp_data = '{32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 3; i++) begin
            step();
            proc_addr = addrs[i];
            #1;
            checks++;
            if (proc_stall !== 1'b0 || proc_rdata !== exp_data[i] || mem_read !== 1'b0) begin
                errors++;
                $display("FAIL seq_hit_%0d: got stall=%0b data=%0h read=%0b exp stall=0 data=%0h read=0",
                         i, proc_stall, proc_rdata, mem_read, exp_data[i]);
            end
        end
        step();
        proc_read = 1'b0;
        step();
`ifdef ICACHE_STATS_EN
        exp_hits = 4;
        exp_miss = 1;
`else
        exp_hits = 0;
        exp_miss = 0;
`endif
        checks++;
        if (hit_cnt !== exp_hits[15:0] || miss_cnt !== exp_miss[15:0]) begin
            errors++; $display("FAIL stats: got hit=%0d miss=%0d exp hit=%0d miss=%0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
    endtask

    task automatic test_conflict();
        proc_read = 1'b1;
        proc_addr = 32'h80;
        #1;
        checks++;
        if (proc_stall !== 1'b1) begin errors++; $display("FAIL conf_miss: got %0b exp 1", proc_stall); end
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h8) begin
            errors++; $display("FAIL conf_req: got read=%0b addr=%0h exp read=1 addr=8", mem_read, mem_addr);
        end
        proc_addr = 32'h44;
        step();
        checks++;
        if (mem_addr !== 28'h8 || proc_stall !== 1'b1) begin
            errors++; $display("FAIL conf_hold: got addr=%0h stall=%0b exp addr=8 stall=1", mem_addr, proc_stall);
        end
        step();
        mem_ready = 1'b1;
        mem_rdata = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
        step();
        mem_ready = 1'b0;
        mem_rdata = 128'h0;
        proc_addr = 32'h80;
        #1;
        checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'hAA) begin
            errors++; $display("FAIL conf_fill_hit: got stall=%0b data=%0h exp stall=0 data=aa", proc_stall, proc_rdata);
        end
        step();
        proc_addr = 32'h0;
        #1;
        checks++;
        if (proc_stall !== 1'b1) begin errors++; $display("FAIL conf_evicted: got %0b exp 1", proc_stall); end
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0) begin
            errors++; $display("FAIL conf_refetch: got read=%0b addr=%0h exp read=1 addr=0", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        mem_ready = 1'b0;
        mem_rdata = 128'h0;
        #1;
        checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h11) begin
            errors++; $display("FAIL conf_refill_hit: got stall=%0b data=%0h exp stall=0 data=11", proc_stall, proc_rdata);
        end
    endtask

    task automatic test_reset_mid_fetch();
        step();
        proc_addr = 32'h20;
        step();
        checks++;
        if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_pre_read: got %0b exp 1", mem_read); end
        #1;
        proc_read = 1'b0;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_addr !== 28'h0) begin
            errors++; $display("FAIL rst_async: got read=%0b addr=%0h exp read=0 addr=0", mem_read, mem_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        mem_ready = 1'b1;
        mem_rdata = {32'h99, 32'h88, 32'h77, 32'h66};
        #1;
        checks++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got stall=%0b read=%0b exp stall=0 read=0", proc_stall, mem_read);
        end
        step();
        mem_ready = 1'b0;
        mem_rdata = 128'h0;
        #1;
        checks++;
        if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_ready_after: got %0b exp 0", mem_read); end
        proc_read = 1'b1;
        proc_addr = 32'h20;
        #1;
        checks++;
        if (proc_stall !== 1'b1 || proc_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_discard: got stall=%0b data=%0h exp stall=1 data=0", proc_stall, proc_rdata);
        end
        proc_addr = 32'h0;
        #1;
        checks++;
        if (proc_stall !== 1'b1) begin errors++; $display("FAIL rst_valid_clr: got %0b exp 1", proc_stall); end
        step();
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0) begin
            errors++; $display("FAIL rst_refetch: got read=%0b addr=%0h exp read=1 addr=0", mem_read, mem_addr);
        end
        step();
        step();
        mem_ready = 1'b1;
        mem_rdata = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        mem_ready = 1'b0;
        proc_addr = 32'h8;
        #1;
        checks++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h33) begin
            errors++; $display("FAIL rst_final_hit: got stall=%0b data=%0h exp stall=0 data=33", proc_stall, proc_rdata);
        end
        proc_read = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
